multi_cycle_adder: RTL and testbench
====================================

# multi_cycle_adder

Parametrised multi-cycle adder/subtractor for the FPGA course designs. It accepts WIDTH-bit operands over a valid/ready handshake and processes them CHUNK bits per clock through a registered carry. It returns the sum, carry-out and signed-overflow flag over a second valid/ready handshake. It replaces the single-bit combinational full adder wherever wide arithmetic must trade latency for area.

## Interface
- WIDTH, default 8: operand and result width; must be ≥ 1.
- CHUNK, default 1: bits processed per cycle; must divide WIDTH. STEPS = WIDTH/CHUNK.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when op=0.
- op  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result.
- cout  out  1  final carry. For subtract, 1 means no borrow.
- ovf  out  1  signed overflow.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid && in_ready, register a and b_eff. b_eff = b for op=0 and ~b for op=1.
  - Set carry = cin for op=0 and 1 for op=1. Set step=0. Go to RUN.
- RUN:
  - in_ready=0 and out_valid=0.
  - Each cycle, add slice [step*CHUNK +: CHUNK] of A and B_eff plus carry.
  - Write the CHUNK-bit result into the same slice of the sum register and update carry.
  - At step = STEPS-1, also capture ovf = carry into MSB XOR carry out of MSB. Then go to DONE. Otherwise step increments.
- DONE:
  - out_valid=1 and in_ready=0.
  - sum, cout and ovf hold stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE.
  - No new operand is accepted in the same cycle as the handoff.
- Arithmetic:
  - {cout,sum} = a + b + cin for op=0.
  - {cout,sum} = a + ~b + 1 for op=1.
  - Results wrap modulo 2^WIDTH. No saturation.
- Inputs a, b, cin and op are sampled only on the accept edge. Later changes are ignored.
- Reset:
  - rst_n=0 at any edge forces IDLE from any state, including mid-RUN or DONE.
  - Reset clears sum, cout, ovf, carry and step to 0.
  - Any in-flight operation is discarded without producing a result.
- step counter width is $clog2(STEPS), minimum 1 bit. step never exceeds STEPS-1.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. All outputs are registered or decoded from state.
- Latency: the accept edge is edge 0. out_valid rises after edge STEPS.
  - WIDTH=8, CHUNK=1: 8 cycles.
  - WIDTH=8, CHUNK=4: 2 cycles.
  - CHUNK=WIDTH: 1 cycle.
- Throughput: one operation per STEPS+2 cycles when out_ready is held high.
- sum holds partial, unspecified content during RUN. It is valid only while out_valid=1.
- Simultaneous rst_n=0 with a handshake: reset wins and no transfer occurs.

## Structure
- Shared package adder_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - op encoding constants OP_ADD=1'b0 and OP_SUB=1'b1.
- Sub-module chunk_adder (parameter CHUNK) is a combinational ripple of CHUNK full adders:
  - inputs: x, y, ci
  - outputs: s, co, c_msb_in (carry into the top bit, used for ovf).
- Top level holds the FSM, the step counter, operand/sum registers and the carry flop. Slice selection uses indexed part-select.

## Test plan
- Add wrap, WIDTH=8, CHUNK=1: a=FF, b=01, cin=0, op=0 → after 8 cycles sum=00, cout=1, ovf=0.
- Subtract with borrow: a=05, b=07, op=1, cin=1 (ignored) → sum=FE, cout=0, ovf=0. Subtract without borrow: a=07, b=05 → sum=02, cout=1.
- Signed overflow: a=7F, b=01, op=0 → sum=80, ovf=1. For op=1, a=80, b=01 → sum=7F, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum, cout, ovf and out_valid=1 are stable, in_ready=0, and new in_valid is ignored. Release → IDLE next cycle.
- Reset mid-operation: drop rst_n for one edge during RUN step 3 → next cycle in_ready=1, out_valid=0, sum=0. A following op a=10, b=20 yields 30.
- Exhaustive sweep, WIDTH=4, CHUNK=2: all a, b, cin and op combinations → {cout,sum} matches the reference model. Latency is exactly 2 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the multi-cycle adder
// Contents: state_t controller states, OP_ADD/OP_SUB operation encodings.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational ripple of CHUNK full adders
// Ports: x, y (CHUNK-bit addends), ci (carry in), s (CHUNK-bit sum),
//        co (carry out of the top bit), c_msb_in (carry into the top bit).
module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co       = c[CHUNK];
  // The carry into the top bit is kept so the caller can form signed overflow.
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/multi_cycle_adder.sv
// rtl/multi_cycle_adder.sv - WIDTH-bit adder/subtractor working CHUNK bits per clock
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready handshake with
//        operands a, b, cin, op (0 add, 1 subtract); out_valid/out_ready
//        handshake with results sum, cout (1 = no borrow on subtract), ovf.
module multi_cycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             ovf_reg;
  logic [SW-1:0]    step;
  logic [IW-1:0]    base;
  logic [CHUNK-1:0] s_chunk;
  logic             co_chunk;
  logic             c_msb;

  // Bit offset of the slice handled in the current step.
  assign base = IW'(32'(step) * CHUNK);

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .x       (a_reg[base +: CHUNK]),
    .y       (b_reg[base +: CHUNK]),
    .ci      (carry),
    .s       (s_chunk),
    .co      (co_chunk),
    .c_msb_in(c_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (step == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Handoff returns to IDLE; in_ready is low here, so no operand
        // can be taken on the same edge.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      ovf_reg <= 1'b0;
      step    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            b_reg <= (op == OP_SUB) ? ~b : b;
            carry <= (op == OP_SUB) ? 1'b1 : cin;
            step  <= '0;
          end
        end
        RUN: begin
          sum_reg[base +: CHUNK] <= s_chunk;
          carry                  <= co_chunk;
          if (step == LAST_STEP) begin
            ovf_reg <= c_msb ^ co_chunk;
          end else begin
            step <= step + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = carry;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb/tb_multi_cycle_adder.sv - self-checking bench for multi_cycle_adder
// Instances: u_dut8 (WIDTH=8, CHUNK=1) and u_dut4 (WIDTH=4, CHUNK=2).
module tb_multi_cycle_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid_8, in_ready_8, cin_8, op_8, out_valid_8, out_ready_8, cout_8, ovf_8;
  logic [7:0] a_8, b_8, sum_8;
  logic       in_valid_4, in_ready_4, cin_4, op_4, out_valid_4, out_ready_4, cout_4, ovf_4;
  logic [3:0] a_4, b_4, sum_4;

  multi_cycle_adder #(.WIDTH(8), .CHUNK(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .a(a_8), .b(b_8), .cin(cin_8), .op(op_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .sum(sum_8), .cout(cout_8), .ovf(ovf_8)
  );

  multi_cycle_adder #(.WIDTH(4), .CHUNK(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .a(a_4), .b(b_4), .cin(cin_4), .op(op_4), .out_valid(out_valid_4),
    .out_ready(out_ready_4), .sum(sum_4), .cout(cout_4), .ovf(ovf_4)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       op;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: unsigned result from plain integer arithmetic, overflow from
  // whether the true signed result fits in WIDTH bits.
  function automatic void ref_model(input int w, input int a, input int b, input int cin,
                                    input int op, output int s, output int co, output int ov);
    int mask, half, t, sa, sb, r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    t    = op ? (a + ((~b) & mask) + 1) : (a + b + cin);
    s    = t & mask;
    co   = (t >> w) & 1;
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    r    = op ? (sa - sb) : (sa + sb + cin);
    ov   = (r < -half || r > half - 1) ? 1 : 0;
  endfunction

  // Called at a negedge with the DUT idle; returns after the result handoff.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic to,
                      output logic [7:0] rs, output logic rc, output logic ro, output int lat);
    a_8 = ta; b_8 = tb; cin_8 = tc; op_8 = to; in_valid_8 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid_8 = 1'b0;
    a_8 = 8'($urandom); b_8 = 8'($urandom); cin_8 = 1'($urandom); op_8 = 1'($urandom);
    lat = 0;
    while (!out_valid_8 && lat < 50) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    rs = sum_8; rc = cout_8; ro = ovf_8;
    out_ready_8 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready_8 = 1'b0;
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc, input logic to,
                      output logic [3:0] rs, output logic rc, output logic ro, output int lat);
    a_4 = ta; b_4 = tb; cin_4 = tc; op_4 = to; in_valid_4 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid_4 = 1'b0;
    a_4 = 4'($urandom); b_4 = 4'($urandom);
    lat = 0;
    while (!out_valid_4 && lat < 50) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    rs = sum_4; rc = cout_4; ro = ovf_4;
    out_ready_4 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready_4 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s8;
    logic [3:0] s4;
    logic       rc, ro;
    int         lat, es, ec, eo;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid_8 = 0; cin_8 = 0; op_8 = 0; out_ready_8 = 0; a_8 = 0; b_8 = 0;
    in_valid_4 = 0; cin_4 = 0; op_4 = 0; out_ready_4 = 0; a_4 = 0; b_4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("reset_in_ready", in_ready_8, 1);
    chk("reset_out_valid", out_valid_8, 0);
    chk("reset_sum", sum_8, 0);
    chk("reset_cout", cout_8, 0);
    chk("reset_ovf", ovf_8, 0);
    chk("reset_in_ready4", in_ready_4, 1);
    chk("reset_out_valid4", out_valid_4, 0);

    // Directed vectors on the 8-bit, 1-bit-per-cycle instance.
    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, s8, rc, ro, lat);
      chk($sformatf("vec%0d_sum", i), s8, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), rc, vecs[i].cout);
      chk($sformatf("vec%0d_ovf", i), ro, vecs[i].ovf);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_idle_after", i), in_ready_8, 1);
    end

    // Backpressure: result held for 5 cycles while new operands are offered.
    a_8 = 8'h12; b_8 = 8'h34; cin_8 = 0; op_8 = 0; in_valid_8 = 1;
    @(posedge clk); @(negedge clk);
    in_valid_8 = 0;
    lat = 0;
    while (!out_valid_8 && lat < 50) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    chk("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid_8 = 1; a_8 = 8'($urandom); b_8 = 8'($urandom);
      chk($sformatf("bp%0d_out_valid", i), out_valid_8, 1);
      chk($sformatf("bp%0d_in_ready", i), in_ready_8, 0);
      chk($sformatf("bp%0d_sum", i), sum_8, 8'h46);
      chk($sformatf("bp%0d_cout", i), cout_8, 0);
      chk($sformatf("bp%0d_ovf", i), ovf_8, 0);
      @(posedge clk); @(negedge clk);
    end
    // in_valid stays high across the handoff edge; it must not be taken.
    out_ready_8 = 1;
    @(posedge clk); @(negedge clk);
    out_ready_8 = 0; in_valid_8 = 0;
    chk("bp_release_in_ready", in_ready_8, 1);
    chk("bp_release_out_valid", out_valid_8, 0);
    @(posedge clk); @(negedge clk);
    chk("bp_still_idle", in_ready_8, 1);

    // Reset during RUN step 3 (accept is edge 0, step 3 executes at edge 4).
    a_8 = 8'hAA; b_8 = 8'h55; cin_8 = 0; op_8 = 0; in_valid_8 = 1;
    @(posedge clk); @(negedge clk);
    in_valid_8 = 0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("rst_mid_run_busy", in_ready_8, 0);
    rst_n = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    chk("rst_mid_in_ready", in_ready_8, 1);
    chk("rst_mid_out_valid", out_valid_8, 0);
    chk("rst_mid_sum", sum_8, 0);
    chk("rst_mid_cout", cout_8, 0);
    chk("rst_mid_ovf", ovf_8, 0);
    repeat (10) begin @(posedge clk); @(negedge clk); end
    chk("rst_mid_no_result", out_valid_8, 0);
    run8(8'h10, 8'h20, 1'b0, 1'b0, s8, rc, ro, lat);
    chk("post_rst_sum", s8, 8'h30);
    chk("post_rst_latency", lat, 8);

    // Randomized 8-bit operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      logic       rcin, rop;
      ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom); rop = 1'($urandom);
      run8(ra, rb, rcin, rop, s8, rc, ro, lat);
      ref_model(8, int'(ra), int'(rb), int'(rcin), int'(rop), es, ec, eo);
      chk($sformatf("rnd%0d_result a=%0h b=%0h c=%0b op=%0b", i, ra, rb, rcin, rop),
          {rc, s8}, 32'(es + (ec << 8)));
      chk($sformatf("rnd%0d_ovf", i), ro, eo);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); @(negedge clk); end
      end
    end

    // Exhaustive 4-bit, 2-bit-per-cycle sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          for (int io = 0; io < 2; io++) begin
            run4(4'(ia), 4'(ib), 1'(ic), 1'(io), s4, rc, ro, lat);
            ref_model(4, ia, ib, ic, io, es, ec, eo);
            chk($sformatf("ex a=%0h b=%0h c=%0d op=%0d result", ia, ib, ic, io),
                {rc, s4}, 32'(es + (ec << 4)));
            chk($sformatf("ex a=%0h b=%0h c=%0d op=%0d ovf", ia, ib, ic, io), ro, eo);
            chk($sformatf("ex a=%0h b=%0h c=%0d op=%0d latency", ia, ib, ic, io), lat, 2);
          end
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
